// File: rtl/vTPU_pkg.sv
// Shared types and constants for the store-path register read controller.
// Holds register-file geometry, store opcodes, FSM state encodings and the
// byte/address payload handed to the four-phase transmitter.
package vTPU_pkg;

  localparam int unsigned NUM_REGS       = 32;
  localparam int unsigned DEF_REG_BYTES  = 16;
  localparam int unsigned DEF_META_BYTES = 4;
  localparam int unsigned DATA_W         = 8;
  localparam int unsigned MEM_ADDR_W     = 16;
  localparam int unsigned OPC_W          = 4;

  localparam logic [OPC_W-1:0] OPC_STORE_META = 4'd0;
  localparam logic [OPC_W-1:0] OPC_STORE_DATA = 4'd1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SEND,
    ACK_LOW,
    DONE
  } rd_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_REQ,
    TX_ACK_LOW
  } tx_state_t;

  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [MEM_ADDR_W-1:0] address;
  } tx_payload_t;

endpackage

// File: rtl/reg_byte_tx.sv
// Four-phase req/ack byte transmitter.
// Ports: clk, rst_n; load + load_payload (byte and destination address to
// send); ack (four-phase acknowledge); data/address (held stable while req
// is high); req (four-phase request); sent_c (one-cycle pulse when ack is
// seen low after the handshake, i.e. the byte is fully delivered).
module reg_byte_tx
  import vTPU_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  tx_payload_t           load_payload,
  input  logic                  ack,
  output logic [DATA_W-1:0]     data,
  output logic [MEM_ADDR_W-1:0] address,
  output logic                  req,
  output logic                  sent_c
);

  tx_state_t state, state_nxt;
  logic      req_nxt;

  // State, request and payload holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= TX_IDLE;
      req     <= 1'b0;
      data    <= '0;
      address <= '0;
    end else begin
      state <= state_nxt;
      req   <= req_nxt;
      if (load) begin
        data    <= load_payload.data;
        address <= load_payload.address;
      end
    end
  end

  // Handshake sequencing: raise req on load, drop on ack, finish on ack low.
  always_comb begin
    state_nxt = state;
    req_nxt   = req;
    sent_c    = 1'b0;
    case (state)
      TX_IDLE: begin
        if (load) begin
          state_nxt = TX_REQ;
          req_nxt   = 1'b1;
        end
      end
      TX_REQ: begin
        if (ack) begin
          state_nxt = TX_ACK_LOW;
          req_nxt   = 1'b0;
        end
      end
      TX_ACK_LOW: begin
        if (!ack) begin
          state_nxt = TX_IDLE;
          sent_c    = 1'b1;
        end
      end
      default: begin
        state_nxt = TX_IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/register_read_controller.sv
// Store-path register read controller: reads one register byte by byte from
// the VEGETA data file (opcode 1) or META file (opcode 0) and ships each
// byte out over a four-phase req/ack bus tagged with memory_address + index.
// Ports: instruction_ready_store/opcode_function/buffer_address/
// memory_address (store request, sampled in IDLE); read_req/read_req_meta/
// read_address/read_byte (register-file read ports); read_data/read_valid and
// read_data_meta/read_valid_meta (read returns); output_data/output_address/
// output_data_req/output_data_ack (outbound bus); store_stage_ready (IDLE),
// store_done and illegal_op (completion pulses).
module register_read_controller
  import vTPU_pkg::*;
#(
  parameter int unsigned REG_BYTES  = DEF_REG_BYTES,
  parameter int unsigned META_BYTES = DEF_META_BYTES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         instruction_ready_store,
  input  logic [3:0]                   opcode_function,
  input  logic [$clog2(NUM_REGS)-1:0]  buffer_address,
  input  logic [15:0]                  memory_address,
  output logic                         read_req,
  output logic                         read_req_meta,
  output logic [$clog2(NUM_REGS)-1:0]  read_address,
  output logic [$clog2(REG_BYTES)-1:0] read_byte,
  input  logic [7:0]                   read_data,
  input  logic                         read_valid,
  input  logic [7:0]                   read_data_meta,
  input  logic                         read_valid_meta,
  output logic [7:0]                   output_data,
  output logic [15:0]                  output_address,
  output logic                         output_data_req,
  input  logic                         output_data_ack,
  output logic                         store_stage_ready,
  output logic                         store_done,
  output logic                         illegal_op
);

  localparam int unsigned BYTE_W = $clog2(REG_BYTES);
  localparam logic [BYTE_W-1:0] LAST_DATA = BYTE_W'(REG_BYTES - 1);
  localparam logic [BYTE_W-1:0] LAST_META = BYTE_W'(META_BYTES - 1);

  rd_state_t         state, state_nxt;
  logic [OPC_W-1:0]  opc_q;
  logic [15:0]       mem_q;
  logic              accept_c, inc_c, load_c, sent_c;
  logic              is_data_c, sel_valid_c, last_c;
  logic              read_req_nxt, read_req_meta_nxt;
  logic              store_done_nxt, illegal_op_nxt;
  tx_payload_t       payload_c;

  assign store_stage_ready = (state == IDLE);

  // Route the selected file's return; the other file's valid is ignored.
  assign is_data_c   = (opc_q == OPC_STORE_DATA);
  assign sel_valid_c = is_data_c ? read_valid : read_valid_meta;
  assign last_c      = (read_byte == (is_data_c ? LAST_DATA : LAST_META));

  always_comb begin
    payload_c.data    = is_data_c ? read_data : read_data_meta;
    payload_c.address = mem_q + 16'(read_byte);
  end

  // State, latched instruction fields, byte counter and registered strobes.
  // read_address/read_byte are the latched index and counter themselves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      opc_q         <= '0;
      mem_q         <= '0;
      read_address  <= '0;
      read_byte     <= '0;
      read_req      <= 1'b0;
      read_req_meta <= 1'b0;
      store_done    <= 1'b0;
      illegal_op    <= 1'b0;
    end else begin
      state         <= state_nxt;
      read_req      <= read_req_nxt;
      read_req_meta <= read_req_meta_nxt;
      store_done    <= store_done_nxt;
      illegal_op    <= illegal_op_nxt;
      if (accept_c) begin
        opc_q        <= opcode_function;
        mem_q        <= memory_address;
        read_address <= buffer_address;
        read_byte    <= '0;
      end else if (inc_c) begin
        read_byte <= read_byte + BYTE_W'(1);
      end
    end
  end

  // Next-state and next-output decode; strobes are set on the edge that
  // enters FETCH so they appear for exactly the FETCH cycle.
  always_comb begin
    state_nxt         = state;
    accept_c          = 1'b0;
    inc_c             = 1'b0;
    load_c            = 1'b0;
    read_req_nxt      = 1'b0;
    read_req_meta_nxt = 1'b0;
    store_done_nxt    = 1'b0;
    illegal_op_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (instruction_ready_store) begin
          accept_c = 1'b1;
          if (opcode_function == OPC_STORE_DATA ||
              opcode_function == OPC_STORE_META) begin
            state_nxt         = FETCH;
            read_req_nxt      = (opcode_function == OPC_STORE_DATA);
            read_req_meta_nxt = (opcode_function == OPC_STORE_META);
          end else begin
            state_nxt      = DONE;
            store_done_nxt = 1'b1;
            illegal_op_nxt = 1'b1;
          end
        end
      end
      FETCH: state_nxt = WAIT;
      WAIT: begin
        if (sel_valid_c) begin
          load_c    = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (output_data_ack) state_nxt = ACK_LOW;
      end
      ACK_LOW: begin
        if (sent_c) begin
          if (last_c) begin
            state_nxt      = DONE;
            store_done_nxt = 1'b1;
          end else begin
            inc_c             = 1'b1;
            state_nxt         = FETCH;
            read_req_nxt      = is_data_c;
            read_req_meta_nxt = !is_data_c;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  reg_byte_tx u_tx (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load_c),
    .load_payload (payload_c),
    .ack          (output_data_ack),
    .data         (output_data),
    .address      (output_address),
    .req          (output_data_req),
    .sent_c       (sent_c)
  );

endmodule

// File: tb/tb_register_read_controller.sv
// Directed testbench for register_read_controller: register-file and ack
// responders driven from small latency tables, a negedge monitor logging
// strobes and transmitted bytes, and one task per scenario.
module tb_register_read_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instruction_ready_store;
  logic [3:0]  opcode_function;
  logic [4:0]  buffer_address;
  logic [15:0] memory_address;
  logic        read_req, read_req_meta;
  logic [4:0]  read_address;
  logic [3:0]  read_byte;
  logic [7:0]  read_data, read_data_meta;
  logic        read_valid, read_valid_meta;
  logic [7:0]  output_data;
  logic [15:0] output_address;
  logic        output_data_req, output_data_ack;
  logic        store_stage_ready, store_done, illegal_op;

  logic       rv_auto, rvm_auto, rvm_force, ack_auto, ack_force;
  logic [7:0] rd_auto, rdm_auto;
  int         lat_tab [8];
  int         ackd_tab [8];

  assign read_valid      = rv_auto;
  assign read_data       = rd_auto;
  assign read_valid_meta = rvm_auto | rvm_force;
  assign read_data_meta  = rvm_force ? 8'hEE : rdm_auto;
  assign output_data_ack = ack_auto | ack_force;

  int n_checks, n_pass;

  always #5 clk = ~clk;

  register_read_controller dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .instruction_ready_store (instruction_ready_store),
    .opcode_function         (opcode_function),
    .buffer_address          (buffer_address),
    .memory_address          (memory_address),
    .read_req                (read_req),
    .read_req_meta           (read_req_meta),
    .read_address            (read_address),
    .read_byte               (read_byte),
    .read_data               (read_data),
    .read_valid              (read_valid),
    .read_data_meta          (read_data_meta),
    .read_valid_meta         (read_valid_meta),
    .output_data             (output_data),
    .output_address          (output_address),
    .output_data_req         (output_data_req),
    .output_data_ack         (output_data_ack),
    .store_stage_ready       (store_stage_ready),
    .store_done              (store_done),
    .illegal_op              (illegal_op)
  );

  // Register-file model: META byte b = 0xA0+b, VEGETA byte b = b.
  initial begin
    int k, lat;
    logic [3:0] b;
    logic m;
    k = 0; rv_auto = 1'b0; rvm_auto = 1'b0; rd_auto = '0; rdm_auto = '0;
    forever begin
      @(negedge clk);
      if (rst_n && (read_req || read_req_meta)) begin
        m = read_req_meta; b = read_byte; lat = lat_tab[k % 8]; k++;
        repeat (lat) @(negedge clk);
        if (m) begin rvm_auto = 1'b1; rdm_auto = 8'hA0 + 8'(b); end
        else begin rv_auto = 1'b1; rd_auto = 8'(b); end
        @(negedge clk);
        rv_auto = 1'b0; rvm_auto = 1'b0;
      end
    end
  end

  // Ack responder: raise ack some cycles after req, drop it once req drops.
  initial begin
    int k, d;
    k = 0; ack_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_auto && !output_data_req) ack_auto = 1'b0;
      else if (!ack_auto && output_data_req) begin
        d = ackd_tab[k % 8]; k++;
        repeat (d) @(negedge clk);
        ack_auto = 1'b1;
      end
    end
  end

  // Monitor logs.
  int         n_str, n_rr, n_rrm, n_tx, n_done, n_ill, n_wide, n_unst, n_early;
  logic [3:0] s_byte [256];
  logic [4:0] s_addr [256];
  logic       s_meta [256];
  logic [7:0] t_data [256];
  logic [15:0] t_addr [256];
  logic       ack_pe;

  always @(posedge clk) ack_pe <= output_data_ack;

  initial begin
    logic p_rr, p_rrm, p_req;
    logic [7:0] p_d;
    logic [15:0] p_a;
    n_str = 0; n_rr = 0; n_rrm = 0; n_tx = 0; n_done = 0; n_ill = 0;
    n_wide = 0; n_unst = 0; n_early = 0;
    p_rr = 0; p_rrm = 0; p_req = 0; p_d = 0; p_a = 0;
    forever begin
      @(negedge clk);
      if ((read_req || read_req_meta) && n_str < 256) begin
        s_byte[n_str] = read_byte; s_addr[n_str] = read_address;
        s_meta[n_str] = read_req_meta; n_str++;
      end
      if (read_req) n_rr++;
      if (read_req_meta) n_rrm++;
      if ((read_req && p_rr) || (read_req_meta && p_rrm)) n_wide++;
      if (output_data_req && !p_req) begin
        if (n_tx < 256) begin t_data[n_tx] = output_data; t_addr[n_tx] = output_address; end
        n_tx++;
      end else if (output_data_req && p_req && (output_data !== p_d || output_address !== p_a))
        n_unst++;
      if (p_req && !output_data_req && !ack_pe && rst_n) n_early++;
      if (store_done) n_done++;
      if (illegal_op) n_ill++;
      p_rr = read_req; p_rrm = read_req_meta; p_req = output_data_req;
      p_d = output_data; p_a = output_address;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_tables(input int lat, input int ackd);
    for (int i = 0; i < 8; i++) begin lat_tab[i] = lat; ackd_tab[i] = ackd; end
  endtask

  task automatic issue(input logic [3:0] opc, input logic [4:0] ba, input logic [15:0] ma);
    @(negedge clk);
    instruction_ready_store = 1'b1;
    opcode_function = opc; buffer_address = ba; memory_address = ma;
  endtask

  task automatic wait_done(input int budget, output int n, output bit seen);
    n = 0; seen = 1'b0;
    while (n < budget) begin
      @(negedge clk); n++;
      if (store_done) begin seen = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({read_req, read_req_meta, read_address, read_byte, output_data, output_address,
         output_data_req, store_done, illegal_op, store_stage_ready} !== {39'd0, 1'b1})
      $display("FAIL reset_outputs: got req=%b meta=%b oreq=%b done=%b ill=%b ready=%b want 0/0/0/0/0/1",
               read_req, read_req_meta, output_data_req, store_done, illegal_op, store_stage_ready);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({store_stage_ready, store_done, read_req, read_req_meta, output_data_req} !== 5'b10000)
      $display("FAIL reset_idle_after_release: got %b want 10000",
               {store_stage_ready, store_done, read_req, read_req_meta, output_data_req});
    else n_pass++;
  endtask

  task automatic test_meta_store();
    int b_str, b_tx, b_done, b_rr, b_rrm, b_ill, b_err, n;
    bit seen;
    set_tables(1, 0);
    @(posedge clk);
    b_str = n_str; b_tx = n_tx; b_done = n_done; b_rr = n_rr; b_rrm = n_rrm; b_ill = n_ill;
    b_err = n_wide + n_unst + n_early;
    issue(4'd0, 5'd3, 16'h0100);
    @(negedge clk); instruction_ready_store = 1'b0;
    n_checks++;
    if ({read_req_meta, read_req, read_address, read_byte} !== {1'b1, 1'b0, 5'd3, 4'd0})
      $display("FAIL meta_first_strobe: got meta=%b req=%b addr=%0d byte=%0d want 1 0 3 0",
               read_req_meta, read_req, read_address, read_byte);
    else n_pass++;
    wait_done(100, n, seen);
    n_checks++;
    if (!seen || n != 16) $display("FAIL meta_done_cycle: got seen=%b n=%0d want 1 16", seen, n);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({store_stage_ready, store_done} !== 2'b10)
      $display("FAIL meta_idle_after: got %b want 10", {store_stage_ready, store_done});
    else n_pass++;
    @(posedge clk);
    n_checks++;
    if (n_rrm - b_rrm != 4 || n_rr - b_rr != 0)
      $display("FAIL meta_strobe_counts: got meta=%0d data=%0d want 4 0", n_rrm - b_rrm, n_rr - b_rr);
    else n_pass++;
    n_checks++;
    if (n_tx - b_tx != 4) $display("FAIL meta_tx_count: got %0d want 4", n_tx - b_tx);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (s_byte[b_str+i] !== 4'(i) || s_addr[b_str+i] !== 5'd3 || s_meta[b_str+i] !== 1'b1 ||
          t_data[b_tx+i] !== 8'hA0 + 8'(i) || t_addr[b_tx+i] !== 16'h0100 + 16'(i))
        $display("FAIL meta_byte%0d: got byte=%0d addr=%h data=%h want byte=%0d addr=%h data=%h",
                 i, s_byte[b_str+i], t_addr[b_tx+i], t_data[b_tx+i], i,
                 16'h0100 + 16'(i), 8'hA0 + 8'(i));
      else n_pass++;
    end
    n_checks++;
    if (n_done - b_done != 1 || n_ill - b_ill != 0 || n_wide + n_unst + n_early != b_err)
      $display("FAIL meta_done_and_protocol: got done=%0d ill=%0d perr=%0d want 1 0 0",
               n_done - b_done, n_ill - b_ill, n_wide + n_unst + n_early - b_err);
    else n_pass++;
  endtask

  task automatic test_vegeta_store();
    int b_str, b_tx, b_done, b_rr, b_rrm, b_err, n;
    bit seen;
    lat_tab  = '{1, 3, 5, 2, 4, 1, 5, 3};
    ackd_tab = '{0, 7, 2, 5, 1, 3, 6, 4};
    @(posedge clk);
    b_str = n_str; b_tx = n_tx; b_done = n_done; b_rr = n_rr; b_rrm = n_rrm;
    b_err = n_wide + n_unst + n_early;
    issue(4'd1, 5'd7, 16'hFFFE);
    @(negedge clk); instruction_ready_store = 1'b0;
    n_checks++;
    if ({read_req, read_req_meta, read_address, read_byte} !== {1'b1, 1'b0, 5'd7, 4'd0})
      $display("FAIL veg_first_strobe: got req=%b meta=%b addr=%0d byte=%0d want 1 0 7 0",
               read_req, read_req_meta, read_address, read_byte);
    else n_pass++;
    wait_done(600, n, seen);
    n_checks++;
    if (!seen || n < 64) $display("FAIL veg_done: got seen=%b n=%0d want 1 >=64", seen, n);
    else n_pass++;
    @(posedge clk);
    n_checks++;
    if (n_rr - b_rr != 16 || n_rrm - b_rrm != 0 || n_tx - b_tx != 16)
      $display("FAIL veg_counts: got data=%0d meta=%0d tx=%0d want 16 0 16",
               n_rr - b_rr, n_rrm - b_rrm, n_tx - b_tx);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (s_byte[b_str+i] !== 4'(i) || s_addr[b_str+i] !== 5'd7 ||
          t_data[b_tx+i] !== 8'(i) || t_addr[b_tx+i] !== 16'(32'hFFFE + i))
        $display("FAIL veg_byte%0d: got byte=%0d addr=%h data=%h want byte=%0d addr=%h data=%h",
                 i, s_byte[b_str+i], t_addr[b_tx+i], t_data[b_tx+i], i,
                 16'(32'hFFFE + i), 8'(i));
      else n_pass++;
    end
    n_checks++;
    if (n_done - b_done != 1 || n_wide + n_unst + n_early != b_err)
      $display("FAIL veg_done_and_protocol: got done=%0d perr=%0d want 1 0",
               n_done - b_done, n_wide + n_unst + n_early - b_err);
    else n_pass++;
  endtask

  task automatic test_illegal();
    int b_str, b_tx, b_done, b_ill;
    set_tables(1, 0);
    @(posedge clk);
    b_str = n_str; b_tx = n_tx; b_done = n_done; b_ill = n_ill;
    issue(4'd5, 5'd1, 16'h4000);
    @(negedge clk); instruction_ready_store = 1'b0;
    n_checks++;
    if ({store_done, illegal_op, read_req, read_req_meta, output_data_req, store_stage_ready} !== 6'b110000)
      $display("FAIL illegal_t1: got %b want 110000",
               {store_done, illegal_op, read_req, read_req_meta, output_data_req, store_stage_ready});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({store_stage_ready, store_done, illegal_op} !== 3'b100)
      $display("FAIL illegal_t2: got %b want 100", {store_stage_ready, store_done, illegal_op});
    else n_pass++;
    repeat (3) @(negedge clk);
    @(posedge clk);
    n_checks++;
    if (n_str != b_str || n_tx != b_tx || n_done - b_done != 1 || n_ill - b_ill != 1)
      $display("FAIL illegal_side_effects: got str=%0d tx=%0d done=%0d ill=%0d want 0 0 1 1",
               n_str - b_str, n_tx - b_tx, n_done - b_done, n_ill - b_ill);
    else n_pass++;
  endtask

  task automatic test_spurious();
    int b_str, b_tx, b_done, b_rr, b_rrm, b_ill, errs, n;
    bit seen;
    logic prev_strobe;
    set_tables(2, 1);
    @(posedge clk);
    b_str = n_str; b_tx = n_tx; b_done = n_done; b_rr = n_rr; b_rrm = n_rrm; b_ill = n_ill;
    issue(4'd1, 5'd2, 16'h1234);
    @(negedge clk);
    // Keep a different store request pending for the whole transfer.
    opcode_function = 4'd0; buffer_address = 5'd9; memory_address = 16'h0000;
    prev_strobe = 1'b0; seen = 1'b0;
    for (n = 0; n < 600; n++) begin
      ack_force   = read_req;
      rvm_force   = prev_strobe;
      prev_strobe = read_req;
      @(negedge clk);
      if (store_done) begin seen = 1'b1; break; end
    end
    instruction_ready_store = 1'b0; ack_force = 1'b0; rvm_force = 1'b0;
    n_checks++;
    if (!seen) $display("FAIL spur_done: got no store_done within %0d cycles, want done", n);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({store_stage_ready, read_req, read_req_meta} !== 3'b100)
      $display("FAIL spur_idle: got %b want 100", {store_stage_ready, read_req, read_req_meta});
    else n_pass++;
    @(posedge clk);
    n_checks++;
    if (n_rr - b_rr != 16 || n_rrm - b_rrm != 0 || n_tx - b_tx != 16 ||
        n_done - b_done != 1 || n_ill - b_ill != 0)
      $display("FAIL spur_counts: got data=%0d meta=%0d tx=%0d done=%0d ill=%0d want 16 0 16 1 0",
               n_rr - b_rr, n_rrm - b_rrm, n_tx - b_tx, n_done - b_done, n_ill - b_ill);
    else n_pass++;
    errs = 0;
    for (int i = 0; i < 16; i++)
      if (s_byte[b_str+i] !== 4'(i) || s_addr[b_str+i] !== 5'd2 ||
          t_data[b_tx+i] !== 8'(i) || t_addr[b_tx+i] !== 16'h1234 + 16'(i)) errs++;
    n_checks++;
    if (errs != 0) $display("FAIL spur_bytes: got %0d bad bytes want 0", errs);
    else n_pass++;
  endtask

  task automatic test_reset_mid_transfer();
    int b_str, b_tx, b_done, errs, n;
    bit seen, hit;
    set_tables(1, 7);
    @(posedge clk);
    b_done = n_done;
    issue(4'd1, 5'd4, 16'h0200);
    @(negedge clk); instruction_ready_store = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (output_data_req && output_address == 16'h0207) begin hit = 1'b1; break; end
    end
    n_checks++;
    if (!hit) $display("FAIL rst_reach_byte7: got no req on byte 7 want req");
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({read_req, read_req_meta, read_address, read_byte, output_data, output_address,
         output_data_req, store_done, illegal_op, store_stage_ready} !== {39'd0, 1'b1})
      $display("FAIL rst_mid_outputs: got oreq=%b addr=%h data=%h ready=%b want 0 0000 00 1",
               output_data_req, output_address, output_data, store_stage_ready);
    else n_pass++;
    set_tables(1, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    @(posedge clk);
    n_checks++;
    if (n_done != b_done) $display("FAIL rst_no_done: got %0d done pulses want 0", n_done - b_done);
    else n_pass++;
    b_str = n_str; b_tx = n_tx; b_done = n_done;
    issue(4'd0, 5'd1, 16'h0300);
    @(negedge clk); instruction_ready_store = 1'b0;
    n_checks++;
    if ({read_req_meta, read_req, read_address, read_byte} !== {1'b1, 1'b0, 5'd1, 4'd0})
      $display("FAIL rst_restart_strobe: got meta=%b req=%b addr=%0d byte=%0d want 1 0 1 0",
               read_req_meta, read_req, read_address, read_byte);
    else n_pass++;
    wait_done(100, n, seen);
    @(posedge clk);
    errs = 0;
    for (int i = 0; i < 4; i++)
      if (s_byte[b_str+i] !== 4'(i) || t_data[b_tx+i] !== 8'hA0 + 8'(i) ||
          t_addr[b_tx+i] !== 16'h0300 + 16'(i)) errs++;
    n_checks++;
    if (!seen || n_tx - b_tx != 4 || n_done - b_done != 1 || errs != 0)
      $display("FAIL rst_restart_store: got seen=%b tx=%0d done=%0d bad=%0d want 1 4 1 0",
               seen, n_tx - b_tx, n_done - b_done, errs);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    instruction_ready_store = 1'b0; opcode_function = '0;
    buffer_address = '0; memory_address = '0;
    rvm_force = 1'b0; ack_force = 1'b0;
    set_tables(1, 0);
    test_reset();
    test_meta_store();
    test_vegeta_store();
    test_illegal();
    test_spurious();
    test_reset_mid_transfer();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
